// File: rtl/uart_pkg.sv
// Shared UART receiver types and defaults.
// Define UART_RX_PARITY_EN to add the PARITY state.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous bit.
// Both flops reset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic a_resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge a_resetn) begin
    if (!a_resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver, LSB first, one stop bit.
// UART_RX_PARITY_EN adds an even-parity bit and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 a_resetn,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);

  state_t               state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] sr;
  logic                 rx_s;
  logic                 armed;
`ifdef UART_RX_PARITY_EN
  logic                 par;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk      (clk),
    .a_resetn (a_resetn),
    .d        (rx),
    .q        (rx_s)
  );

  // armed blocks restart until the line has been seen idle again
  always_ff @(posedge clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state     <= IDLE;
      tick      <= '0;
      bitcnt    <= '0;
      sr        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
      armed     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par        <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed   <= 1'b0;
            state   <= START;
            tick    <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (b_tick) begin
            if (tick == MID) begin
              tick <= '0;
              if (rx_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state  <= DATA;
                bitcnt <= '0;
`ifdef UART_RX_PARITY_EN
                par    <= 1'b0;
`endif
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        DATA: begin
          if (b_tick) begin
            if (tick == LAST) begin
              tick <= '0;
              sr   <= {rx_s, sr[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
              par  <= par ^ rx_s;
`endif
              if (bitcnt == BMAX) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (b_tick) begin
            if (tick == LAST) begin
              tick  <= '0;
              par   <= par ^ rx_s;
              state <= STOP;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (b_tick) begin
            if (tick == LAST) begin
              tick      <= '0;
              state     <= IDLE;
              rx_busy   <= 1'b0;
              rx_data   <= sr;
              armed     <= rx_s;
              rx_valid  <= rx_s;
              frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err <= par;
`endif
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx; b_tick every 4 clk, 64 clk per bit.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       a_resetn;
  logic       b_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_checks = 0;
  int   n_out = 0;
  int   n_exp = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] last_data = '0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .a_resetn  (a_resetn),
    .b_tick    (b_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    b_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      b_tick = 1'b1;
      @(negedge clk);
      b_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (a_resetn) begin
      if (prev_pulse)
        check("pulse_w", {30'd0, rx_valid, frame_err}, 0);
      if (rx_valid || frame_err) begin
        n_out++;
        check("excl", {31'd0, rx_valid & frame_err}, 0);
        if (sb.size() == 0) begin
          check("unexp", {30'd0, rx_valid, frame_err}, 0);
        end else begin
          e = sb.pop_front();
          check("kind", {30'd0, rx_valid, frame_err},
                e.fe ? 32'd1 : 32'd2);
          check("data", {24'd0, rx_data}, {24'd0, e.data});
`ifdef UART_RX_PARITY_EN
          check("par", {31'd0, parity_err}, {31'd0, e.pe});
`endif
        end
      end else begin
        check("hold", {24'd0, rx_data}, {24'd0, last_data});
      end
      last_data <= rx_data;
    end else begin
      last_data <= '0;
    end
    prev_pulse <= rx_valid | frame_err;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input logic pflip);
    sb.push_back('{fe: ~stop, pe: pflip, data: d});
    n_exp++;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pflip);
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    a_resetn = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 0);
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_busy", {31'd0, rx_busy}, 0);
    a_resetn = 1'b1;
    idle(40);

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("a5_busy", {31'd0, rx_busy}, 0);
    check("a5_data", {24'd0, rx_data}, 32'hA5);
    check("a5_cnt", n_out, 1);

    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(200);
    check("gl_busy", {31'd0, rx_busy}, 0);
    check("gl_data", {24'd0, rx_data}, 32'hA5);
    check("gl_cnt", n_out, 1);

    send_frame(8'h3C, 1'b0, 1'b0);
    idle(100);
    check("fe_data", {24'd0, rx_data}, 32'h3C);
    check("fe_cnt", n_out, 2);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);
    check("b2b_cnt", n_out, 4);
    check("b2b_data", {24'd0, rx_data}, 32'hFF);

    d = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (30) @(negedge clk);
    a_resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'd0, rx_busy}, 0);
    check("mid_data", {24'd0, rx_data}, 0);
    a_resetn = 1'b1;
    idle(200);
    check("mid_cnt", n_out, 4);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    check("r81_data", {24'd0, rx_data}, 32'h81);
    check("r81_cnt", n_out, 5);

    sb.push_back('{fe: 1'b1, pe: 1'b0, data: 8'h00});
    n_exp++;
    rx = 1'b0;
    repeat (64 * 13) @(negedge clk);
    check("brk_busy", {31'd0, rx_busy}, 0);
    check("brk_cnt", n_out, 6);
    idle(128);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(20);
    check("brk_next", {24'd0, rx_data}, 32'h55);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("par_data", {24'd0, rx_data}, 32'h07);
`endif

    idle(50);
    check("sb_empty", sb.size(), 0);
    check("n_out", n_out, n_exp);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
